// File: rtl/tpm_tis_controller_if.sv
// Bundle of LPC register-access signals and the command/response streams to the TPM engine.
// The master side is the environment (LPC peripheral plus engine); the slave side is the controller.
interface tpm_tis_controller_if;
    logic [15:0] lpcAddr;
    logic [7:0]  lpcWrData;
    logic        lpcDidWrite;
    logic        lpcDidRead;
    logic [7:0]  lpcRdData;
    logic [7:0]  cmdData;
    logic        cmdValid;
    logic        cmdLast;
    logic        cmdReady;
    logic [7:0]  rspData;
    logic        rspValid;
    logic        rspLast;
    logic        rspReady;

    modport master (
        output lpcAddr, lpcWrData, lpcDidWrite, lpcDidRead, cmdReady, rspData, rspValid, rspLast,
        input  lpcRdData, cmdData, cmdValid, cmdLast, rspReady
    );

    modport slave (
        input  lpcAddr, lpcWrData, lpcDidWrite, lpcDidRead, cmdReady, rspData, rspValid, rspLast,
        output lpcRdData, cmdData, cmdValid, cmdLast, rspReady
    );
endinterface

// File: rtl/tpm_tis_controller.sv
// Minimal TPM TIS locality-0 register map behind LPC: buffers a command, streams it to
// the TPM engine, buffers the response and hands it back through DATA_FIFO.
module tpm_tis_controller #(
    parameter int unsigned BUF_DEPTH = 64,
    parameter logic [31:0] DID_VID   = 32'h0001_1050
) (
    input  logic                  clk,
    input  logic                  reset,
    tpm_tis_controller_if.slave   bus
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [15:0] ADDR_ACCESS = 16'h0000;
    localparam logic [15:0] ADDR_STS    = 16'h0018;
    localparam logic [15:0] ADDR_BC_LO  = 16'h0019;
    localparam logic [15:0] ADDR_BC_HI  = 16'h001A;
    localparam logic [15:0] ADDR_FIFO   = 16'h0024;
    localparam logic [15:0] ADDR_DID0   = 16'h0F00;
    localparam logic [15:0] ADDR_DID1   = 16'h0F01;
    localparam logic [15:0] ADDR_DID2   = 16'h0F02;
    localparam logic [15:0] ADDR_DID3   = 16'h0F03;

    typedef enum logic [2:0] {
        IDLE, READY, RECEPTION, EXECUTION, COMPLETION
    } state_t;

    state_t          state_q, state_d;
    logic            clr_c;
    logic            active_q;
    logic [CW-1:0]   cmd_count_q, tx_ptr_q, rsp_count_q, rd_ptr_q;
    logic [31:0]     cmd_size_q;
    logic            abort_pend_q, cmd_done_q;
    logic            cmd_valid_q, cmd_last_q, rsp_ready_q;
    logic [7:0]      cmd_data_q, rd_data_q, rd_c;
    logic [7:0]      cmd_buf [BUF_DEPTH];
    logic [7:0]      rsp_buf [BUF_DEPTH];

    logic            access_wr_c, sts_wr_c, fifo_wr_c, push_c, pop_c, rsp_fire_c, rsp_store_c;
    logic            expect_c, cmd_rdy_c, avail_c;
    logic [15:0]     burst_c;

    assign bus.lpcRdData = rd_data_q;
    assign bus.cmdData   = cmd_data_q;
    assign bus.cmdValid  = cmd_valid_q;
    assign bus.cmdLast   = cmd_last_q;
    assign bus.rspReady  = rsp_ready_q;

    // Access decode; everything but ACCESS is gated by the granted locality
    assign access_wr_c = bus.lpcDidWrite && (bus.lpcAddr == ADDR_ACCESS);
    assign sts_wr_c    = bus.lpcDidWrite && active_q && (bus.lpcAddr == ADDR_STS);
    assign fifo_wr_c   = bus.lpcDidWrite && active_q && (bus.lpcAddr == ADDR_FIFO) &&
                         ((state_q == READY) || (state_q == RECEPTION));
    assign push_c      = fifo_wr_c && (cmd_count_q < CW'(BUF_DEPTH));
    assign avail_c     = (state_q == COMPLETION) && (rd_ptr_q < rsp_count_q);
    assign pop_c       = bus.lpcDidRead && !bus.lpcDidWrite && active_q &&
                         (bus.lpcAddr == ADDR_FIFO) && avail_c;
    assign rsp_fire_c  = (state_q == EXECUTION) && bus.rspValid && rsp_ready_q;
    assign rsp_store_c = rsp_fire_c && (rsp_count_q < CW'(BUF_DEPTH));

    assign expect_c  = (state_q == RECEPTION) &&
                       ((cmd_count_q < CW'(6)) || (32'(cmd_count_q) < cmd_size_q));
    assign cmd_rdy_c = (state_q == READY) || (state_q == RECEPTION);

    always_comb begin
        burst_c = 16'h0000;
        if (cmd_rdy_c)
            burst_c = 16'(BUF_DEPTH) - 16'(cmd_count_q);
        else if (state_q == COMPLETION)
            burst_c = 16'(rsp_count_q) - 16'(rd_ptr_q);
    end

    // Read data mux, registered every cycle into lpcRdData
    always_comb begin
        rd_c = 8'hFF;
        case (bus.lpcAddr)
            ADDR_ACCESS: rd_c = {1'b1, 1'b0, active_q, 5'b0};
            ADDR_DID0:   rd_c = DID_VID[7:0];
            ADDR_DID1:   rd_c = DID_VID[15:8];
            ADDR_DID2:   rd_c = DID_VID[23:16];
            ADDR_DID3:   rd_c = DID_VID[31:24];
            ADDR_STS:    if (active_q) rd_c = {1'b1, cmd_rdy_c, 1'b0, avail_c, expect_c, 3'b0};
            ADDR_BC_LO:  if (active_q) rd_c = burst_c[7:0];
            ADDR_BC_HI:  if (active_q) rd_c = burst_c[15:8];
            ADDR_FIFO:   if (active_q && avail_c) rd_c = rsp_buf[rd_ptr_q[AW-1:0]];
            default:     rd_c = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Command life-cycle sequencing; clr_c flushes buffers on entry to IDLE/READY
    always_comb begin
        state_d = state_q;
        clr_c   = 1'b0;
        if (access_wr_c && bus.lpcWrData[5]) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       if (sts_wr_c && bus.lpcWrData[6]) state_d = READY;
                READY:      if (fifo_wr_c) state_d = RECEPTION;
                RECEPTION: begin
                    if (sts_wr_c && bus.lpcWrData[6])
                        state_d = READY;
                    else if (sts_wr_c && bus.lpcWrData[5] && !expect_c)
                        state_d = EXECUTION;
                end
                EXECUTION: begin
                    if (rsp_fire_c && bus.rspLast)
                        state_d = (abort_pend_q || (sts_wr_c && bus.lpcWrData[6])) ? READY : COMPLETION;
                end
                COMPLETION: if (sts_wr_c && bus.lpcWrData[6]) state_d = READY;
                default:    state_d = IDLE;
            endcase
        end
        clr_c = (state_d != state_q) && ((state_d == IDLE) || (state_d == READY));
    end

    always_ff @(posedge clk) begin
        if (push_c)      cmd_buf[cmd_count_q[AW-1:0]] <= bus.lpcWrData;
        if (rsp_store_c) rsp_buf[rsp_count_q[AW-1:0]] <= bus.rspData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q    <= 8'hFF;
            active_q     <= 1'b0;
            cmd_count_q  <= '0;
            tx_ptr_q     <= '0;
            rsp_count_q  <= '0;
            rd_ptr_q     <= '0;
            cmd_size_q   <= '0;
            abort_pend_q <= 1'b0;
            cmd_done_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_last_q   <= 1'b0;
            cmd_data_q   <= 8'h00;
            rsp_ready_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_c;
            if (access_wr_c) begin
                if (bus.lpcWrData[5])      active_q <= 1'b0;
                else if (bus.lpcWrData[1]) active_q <= 1'b1;
            end
            if (clr_c) begin
                cmd_count_q  <= '0;
                tx_ptr_q     <= '0;
                rsp_count_q  <= '0;
                rd_ptr_q     <= '0;
                cmd_size_q   <= '0;
                abort_pend_q <= 1'b0;
                cmd_done_q   <= 1'b0;
                cmd_valid_q  <= 1'b0;
                cmd_last_q   <= 1'b0;
                rsp_ready_q  <= 1'b0;
            end else begin
                if (push_c) begin
                    cmd_count_q <= cmd_count_q + CW'(1);
                    // Bytes 2..5 carry the big-endian command size
                    if (cmd_count_q >= CW'(2) && cmd_count_q <= CW'(5))
                        cmd_size_q <= {cmd_size_q[23:0], bus.lpcWrData};
                end
                if (state_q == EXECUTION) begin
                    if (sts_wr_c && bus.lpcWrData[6]) abort_pend_q <= 1'b1;
                    if (cmd_valid_q && bus.cmdReady && cmd_last_q) begin
                        cmd_valid_q <= 1'b0;
                        cmd_last_q  <= 1'b0;
                        cmd_done_q  <= 1'b1;
                        rsp_ready_q <= 1'b1;
                    end else if (!cmd_done_q && (!cmd_valid_q || bus.cmdReady)) begin
                        cmd_valid_q <= 1'b1;
                        cmd_data_q  <= cmd_buf[tx_ptr_q[AW-1:0]];
                        cmd_last_q  <= (tx_ptr_q == cmd_count_q - CW'(1));
                        tx_ptr_q    <= tx_ptr_q + CW'(1);
                    end
                    if (rsp_store_c) rsp_count_q <= rsp_count_q + CW'(1);
                    if (rsp_fire_c && bus.rspLast) rsp_ready_q <= 1'b0;
                end
                if (state_q == COMPLETION) begin
                    if (sts_wr_c && bus.lpcWrData[1]) rd_ptr_q <= '0;
                    else if (pop_c)                   rd_ptr_q <= rd_ptr_q + CW'(1);
                end
            end
        end
    end
endmodule
